// File: rtl/image_pkg.sv
// Shared image geometry and writer state encoding for the binary
// image capture path (writer and pixel_cache address math).
package image_pkg;

    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int BYTES_PER_LINE = DEF_IMG_WIDTH / 8;
    localparam int FRAME_BYTES    = BYTES_PER_LINE * DEF_IMG_HEIGHT;

    typedef enum logic {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/bit_packer.sv
// Assembles 8 serial pixel bits into a byte, first bit in the LSB.
// byte_ready flags the cycle in which the 8th bit is presented.
module bit_packer (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_bit,
    input  logic       valid,
    input  logic       clear,
    output logic [7:0] byte_data,
    output logic       byte_ready
);

    logic [7:0] sr_q, sr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] cnt_base;

    always_comb begin
        // clear and valid together: the bit is the first of a new byte
        cnt_base   = clear ? 3'd0 : cnt_q;
        sr_d       = sr_q;
        cnt_d      = cnt_base;
        byte_data  = {pix_bit, sr_q[7:1]};
        byte_ready = valid && (cnt_base == 3'd7);
        if (valid) begin
            sr_d  = {pix_bit, sr_q[7:1]};
            cnt_d = cnt_base + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= 8'd0;
            cnt_q <= 3'd0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/binary_image_writer.sv
// Packs a thresholded raster pixel stream into bytes and writes them
// to image memory at sequential byte addresses, one frame at a time.
module binary_image_writer
    import image_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        pixel_valid,
    input  logic        pixel_bit,
    input  logic        freeze,
    output logic [7:0]  write_data,
    output logic [15:0] wraddress,
    output logic        write_en,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
    localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

    wr_state_e   state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d, addr_q, addr_d;
    logic [15:0] x_b, y_b, a_b;
    logic [15:0] wraddress_q, wraddress_d;
    logic [7:0]  write_data_q, write_data_d;
    logic        write_en_q, write_en_d;
    logic        frame_done_q, frame_done_d;

    logic        accept;
    logic        pk_ready;
    logic [7:0]  pk_byte;

    bit_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .pix_bit    (pixel_bit),
        .valid      (accept),
        .clear      (frame_start),
        .byte_data  (pk_byte),
        .byte_ready (pk_ready)
    );

    always_comb begin
        // frame_start overrides the current state, so its pixel is (0,0)
        if (frame_start) accept = pixel_valid && !freeze;
        else             accept = pixel_valid && (state_q == CAPTURE);

        x_b = frame_start ? 16'd0 : x_q;
        y_b = frame_start ? 16'd0 : y_q;
        a_b = frame_start ? 16'd0 : addr_q;

        state_d      = state_q;
        if (frame_start) state_d = freeze ? IDLE : CAPTURE;
        x_d          = x_b;
        y_d          = y_b;
        addr_d       = a_b;
        write_en_d   = 1'b0;
        frame_done_d = 1'b0;
        write_data_d = write_data_q;
        wraddress_d  = wraddress_q;

        if (accept) begin
            if (pk_ready) begin
                write_en_d   = 1'b1;
                write_data_d = pk_byte;
                wraddress_d  = a_b;
                addr_d       = a_b + 16'd1;
            end
            if (x_b == X_LAST) begin
                x_d = 16'd0;
                if (y_b == Y_LAST) begin
                    y_d          = 16'd0;
                    addr_d       = 16'd0;
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    y_d = y_b + 16'd1;
                end
            end else begin
                x_d = x_b + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= 16'd0;
            y_q          <= 16'd0;
            addr_q       <= 16'd0;
            write_en_q   <= 1'b0;
            frame_done_q <= 1'b0;
            write_data_q <= 8'd0;
            wraddress_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            addr_q       <= addr_d;
            write_en_q   <= write_en_d;
            frame_done_q <= frame_done_d;
            write_data_q <= write_data_d;
            wraddress_q  <= wraddress_d;
        end
    end

    assign write_en   = write_en_q;
    assign frame_done = frame_done_q;
    assign write_data = write_data_q;
    assign wraddress  = wraddress_q;
    assign busy       = (state_q == CAPTURE);

endmodule

// File: tb/tb_binary_image_writer.sv
// Directed checks for binary_image_writer on a 640x4 image so that
// whole frames fit in a short run.
module tb_binary_image_writer;

    localparam int W  = 640;
    localparam int H  = 4;
    localparam int FB = W * H / 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        pixel_valid = 1'b0;
    logic        pixel_bit = 1'b0;
    logic        freeze = 1'b0;
    logic [7:0]  write_data;
    logic [15:0] wraddress;
    logic        write_en;
    logic        busy;
    logic        frame_done;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    int done_cnt = 0;
    int done_ok = 0;
    int busy_cnt = 0;

    binary_image_writer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .pixel_bit   (pixel_bit),
        .freeze      (freeze),
        .write_data  (write_data),
        .wraddress   (wraddress),
        .write_en    (write_en),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_en) begin
            wa_q.push_back(wraddress);
            wd_q.push_back(write_data);
        end
        if (frame_done) begin
            done_cnt++;
            if (write_en && wraddress == 16'(FB - 1)) done_ok++;
        end
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic b, input logic fs);
        pixel_valid = 1'b1;
        pixel_bit   = b;
        frame_start = fs;
        step();
        pixel_valid = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        done_ok  = 0;
        busy_cnt = 0;
    endtask

    initial begin
        logic [7:0] p1;
        logic [7:0] p2;
        int seq_bad;
        int ff_cnt;
        logic b;

        // reset state
        step();
        step();
        check("rst_we", write_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_data", write_data, 8'h00);
        check("rst_addr", wraddress, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        step();
        clear_log();

        // first byte: 1,0,0,0,0,0,0,1 -> 0x81 at 0
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("busy_cap", busy, 1'b1);
        p1 = 8'h81;
        for (int i = 0; i < 8; i++) begin
            check("no_early_we", write_en, 1'b0);
            pix(p1[i], 1'b0);
        end
        check("we_n1", write_en, 1'b1);
        check("data_81", write_data, 8'h81);
        check("addr_0", wraddress, 16'h0000);
        step();
        check("we_one_cyc", write_en, 1'b0);
        check("data_hold", write_data, 8'h81);

        // 5 more pixels, then restart with pixel (0,0) in the same cycle
        for (int i = 0; i < 5; i++) pix(1'b1, 1'b0);
        p2 = 8'h06;
        pix(p2[0], 1'b1);
        for (int i = 1; i < 8; i++) pix(p2[i], 1'b0);
        step();
        check("abort_nwr", wa_q.size(), 2);
        if (wa_q.size() == 2) begin
            check("abort_addr", wa_q[1], 16'h0000);
            check("abort_data", wd_q[1], 8'h06);
        end
        check("abort_done", done_cnt, 0);

        // async reset between edges while write_en is high
        for (int i = 0; i < 8; i++) pix(1'b1, 1'b0);
        check("pre_rst_we", write_en, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_we", write_en, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", frame_done, 1'b0);
        check("arst_addr", wraddress, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        step();
        clear_log();

        // full all-ones frame, freeze toggled mid-frame
        for (int i = 0; i < W * H; i++) begin
            freeze = (i >= 1000 && i < 1100);
            pix(1'b1, i == 0);
        end
        freeze = 1'b0;
        step();
        step();
        check("full_nwr", wa_q.size(), FB);
        seq_bad = 0;
        ff_cnt = 0;
        foreach (wa_q[i]) begin
            if (wa_q[i] != 16'(i)) seq_bad++;
            if (wd_q[i] == 8'hFF) ff_cnt++;
        end
        check("full_seq", seq_bad, 0);
        check("full_ff", ff_cnt, FB);
        check("full_done", done_cnt, 1);
        check("done_w_last", done_ok, 1);
        check("full_busy_off", busy, 1'b0);

        // idle pixels after a frame are ignored
        for (int i = 0; i < 16; i++) pix(1'b1, 1'b0);
        step();
        check("idle_nwr", wa_q.size(), FB);
        clear_log();

        // pixel_valid toggling across line 0 and into line 1
        for (int j = 0; j < W + 8; j++) begin
            if (j < W) b = (j >= W - 8);
            else       b = ((j - W) < 2);
            pix(b, j == 0);
            step();
        end
        step();
        check("tog_nwr", wa_q.size(), 81);
        if (wa_q.size() == 81) begin
            check("tog_a78", wd_q[78], 8'h00);
            check("tog_addr79", wa_q[79], 16'd79);
            check("tog_data79", wd_q[79], 8'hFF);
            check("tog_addr80", wa_q[80], 16'd80);
            check("tog_data80", wd_q[80], 8'h03);
        end

        // frame_start with freeze during capture drops to idle
        freeze = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("frz_abort_busy", busy, 1'b0);
        clear_log();

        // frozen frame: nothing captured
        for (int i = 0; i < W * H; i++) pix(1'b1, i == 0);
        step();
        step();
        freeze = 1'b0;
        check("frz_nwr", wa_q.size(), 0);
        check("frz_busy", busy_cnt, 0);
        check("frz_done", done_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
